// File: rtl/speed_throttle.sv
// Push-button speed selector driving a divided square wave (slow_clk) and tick pulse.
// Optional feature macro: THROTTLE_AUTOREPEAT_EN (auto-repeat steps while a button is held).

module speed_throttle_btn #(
  parameter int DB_CYCLES = 250000
) (
  input  logic CLK_50,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;
  logic            level_q;

  // Level follows the synchronised input only after DB_CYCLES identical samples in a row.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      if (sync[1] != level) begin
        if (cnt == DB_W'(DB_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;
endmodule

module speed_throttle #(
  parameter int NUM_LEVELS    = 6,
  parameter int BASE_HALF     = 12500000,
  parameter int CNT_WIDTH     = 24,
  parameter int DB_CYCLES     = 250000,
  parameter int REPEAT_CYCLES = 25000000,
  parameter int LVL_W         = 3
) (
  input  logic             CLK_50,
  input  logic             reset_n,
  input  logic             pb_freq_up,
  input  logic             pb_freq_dn,
  output logic             slow_clk,
  output logic             tick,
  output logic [LVL_W-1:0] freq_num,
  output logic             at_min,
  output logic             at_max
);
  localparam int TBL = 1 << LVL_W;

  logic [1:0] db_lvl, db_rise;   // [0] = up, [1] = down
  logic       up_req, dn_req;

  speed_throttle_btn #(.DB_CYCLES(DB_CYCLES)) u_btn [1:0] (
    .CLK_50  (CLK_50),
    .reset_n (reset_n),
    .raw     ({pb_freq_dn, pb_freq_up}),
    .level   (db_lvl),
    .rise    (db_rise)
  );

`ifdef THROTTLE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             single, rep_fire;

  // Counter idles during the press cycle so the first repeat lands REPEAT_CYCLES after it.
  assign single   = db_lvl[0] ^ db_lvl[1];
  assign rep_fire = single && (db_rise == 2'b00) && (rep_cnt == REP_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n)                               rep_cnt <= '0;
    else if (!single || db_rise != 2'b00 || rep_fire) rep_cnt <= '0;
    else                                        rep_cnt <= rep_cnt + 1'b1;
  end

  assign up_req = db_rise[0] | (rep_fire & db_lvl[0]);
  assign dn_req = db_rise[1] | (rep_fire & db_lvl[1]);
`else
  assign up_req = db_rise[0];
  assign dn_req = db_rise[1];
`endif

  // Per-level terminal counts, fixed at elaboration.
  logic [TBL-1:0][CNT_WIDTH-1:0] half_m1;
  for (genvar g = 0; g < TBL; g++) begin : g_half
    if (g < NUM_LEVELS) begin : g_lvl
      assign half_m1[g] = CNT_WIDTH'((BASE_HALF >> g) - 1);
    end else begin : g_pad
      assign half_m1[g] = '0;
    end
  end

  logic [LVL_W-1:0]     lvl_nxt;
  logic [CNT_WIDTH-1:0] cnt;

  assign at_min = (freq_num == '0);
  assign at_max = (freq_num == LVL_W'(NUM_LEVELS - 1));

  always_comb begin
    lvl_nxt = freq_num;
    if (up_req && !dn_req && !at_max)      lvl_nxt = freq_num + 1'b1;
    else if (dn_req && !up_req && !at_min) lvl_nxt = freq_num - 1'b1;
  end

  // A level change restarts the period and swallows any toggle due on that edge.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      freq_num <= '0;
      cnt      <= '0;
      slow_clk <= 1'b0;
      tick     <= 1'b0;
    end else begin
      freq_num <= lvl_nxt;
      tick     <= 1'b0;
      if (lvl_nxt != freq_num) begin
        cnt <= '0;
      end else if (cnt == half_m1[freq_num]) begin
        cnt      <= '0;
        slow_clk <= ~slow_clk;
        tick     <= ~slow_clk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_speed_throttle.sv
// Directed + randomized bench for speed_throttle (4 levels, base half-period 16, debounce 4).
module tb_speed_throttle;
  logic       CLK_50 = 1'b0;
  logic       reset_n, pb_freq_up, pb_freq_dn;
  logic       slow_clk, tick, at_min, at_max;
  logic [2:0] freq_num;

  int   errors = 0, checks = 0, cyc = 0, lvl = 0;
  logic prev_slow = 1'b0;

  always #5 CLK_50 = ~CLK_50;

  speed_throttle #(
    .NUM_LEVELS(4), .BASE_HALF(16), .CNT_WIDTH(5),
    .DB_CYCLES(4), .REPEAT_CYCLES(20), .LVL_W(3)
  ) dut (
    .CLK_50(CLK_50), .reset_n(reset_n), .pb_freq_up(pb_freq_up), .pb_freq_dn(pb_freq_dn),
    .slow_clk(slow_clk), .tick(tick), .freq_num(freq_num), .at_min(at_min), .at_max(at_max)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample after the edge; tick must mark exactly the 0->1 edges of slow_clk.
  task automatic step();
    @(posedge CLK_50); #1;
    cyc++;
    chk("tick_on_rise", {31'd0, tick}, {31'd0, slow_clk & ~prev_slow});
    prev_slow = slow_clk;
  endtask

  task automatic check_lvl();
    chk("freq_num", {29'd0, freq_num}, lvl);
    chk("at_min", {31'd0, at_min}, {31'd0, lvl == 0});
    chk("at_max", {31'd0, at_max}, {31'd0, lvl == 3});
  endtask

  task automatic press(input bit up, input bit dn, input bit bounce, input int hold);
    pb_freq_up = up; pb_freq_dn = dn;
    if (bounce) begin
      step();
      pb_freq_up = 1'b0; pb_freq_dn = 1'b0;
      step();
      pb_freq_up = up; pb_freq_dn = dn;
    end
    repeat (hold) step();
    pb_freq_up = 1'b0; pb_freq_dn = 1'b0;
    repeat (12) step();
    if (up && !dn)      lvl = (lvl < 3) ? lvl + 1 : 3;
    else if (dn && !up) lvl = (lvl > 0) ? lvl - 1 : 0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 200);
    chk("tick_seen", {31'd0, tick}, 1);
  endtask

  task automatic measure(input int half);
    int t0, th, n;
    wait_tick();
    t0 = cyc; n = 0;
    do begin step(); n++; end while (slow_clk === 1'b1 && n < 200);
    th = cyc - t0;
    wait_tick();
    chk("period", cyc - t0, 2 * half);
    chk("high_time", th, half);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; pb_freq_up = 1'b0; pb_freq_dn = 1'b0;
    step(); step();
    chk("rst_freq", {29'd0, freq_num}, 0);
    chk("rst_slow", {31'd0, slow_clk}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_at_min", {31'd0, at_min}, 1);
    chk("rst_at_max", {31'd0, at_max}, 0);

    reset_n = 1'b1;
    measure(16);
    check_lvl();

    press(1, 0, 1, 10);               // bounced press -> exactly one step
    check_lvl();
    measure(8);

    repeat (5) press(1, 0, 0, 10);    // saturate at top
    check_lvl();
    measure(2);
    press(1, 1, 0, 10);               // simultaneous -> unchanged
    check_lvl();

    repeat (6) press(0, 1, 0, 10);    // down to 0, then three more saturating
    check_lvl();
    measure(16);

    for (int i = 0; i < 24; i++) begin
      int op;
      op = $urandom_range(0, 2);
      press(op != 1, op != 0, 1'($urandom_range(0, 1)), $urandom_range(8, 14));
      check_lvl();
      if (i % 4 == 3) measure(16 >> lvl);
    end

    while (lvl < 2) press(1, 0, 0, 10);
    while (lvl > 2) press(0, 1, 0, 10);
    check_lvl();
    n = 0;
    do begin step(); n++; end while (slow_clk !== 1'b1 && n < 40);
    chk("slow_high_seen", {31'd0, slow_clk}, 1);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_freq", {29'd0, freq_num}, 0);
    chk("async_rst_slow", {31'd0, slow_clk}, 0);
    chk("async_rst_tick", {31'd0, tick}, 0);
    step();
    reset_n = 1'b1;
    lvl = 0;
    measure(16);
    check_lvl();

    reset_n = 1'b0; pb_freq_up = 1'b1;  // button held through reset release
    step(); step();
    chk("held_in_reset", {29'd0, freq_num}, 0);
    reset_n = 1'b1;
    repeat (14) step();
    lvl = 1;
    check_lvl();
    pb_freq_up = 1'b0;
    repeat (12) step();
    check_lvl();

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    pb_freq_up = 1'b1;
    repeat (8) step();
    repeat (70) step();
`ifdef THROTTLE_AUTOREPEAT_EN
    lvl = 3;
`else
    lvl = 1;
`endif
    check_lvl();
    pb_freq_up = 1'b0;
    repeat (12) step();
    check_lvl();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/speed_throttle.md
SPEED_THROTTLE -- requirements
Module: speed_throttle

Interface
REQ-001 Parameter NUM_LEVELS, default 6, number of selectable speed levels (2..8).
REQ-002 Parameter BASE_HALF, default 12500000, half-period in clocks at level 0.
REQ-003 Parameter CNT_WIDTH, default 24, divider counter width (SHALL hold BASE_HALF-1).
REQ-004 Parameter DB_CYCLES, default 250000, consecutive stable clocks required to accept a button level.
REQ-005 Parameter REPEAT_CYCLES, default 25000000, hold time per auto-repeat step (used only under REQ-030).
REQ-006 Parameter LVL_W, default 3, width of freq_num (2**LVL_W >= NUM_LEVELS).
REQ-007 CLK_50  input  1  single clock for the whole block, all logic on the rising edge.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 pb_freq_up  input  1  raw asynchronous push-button, active-high, raises the level.
REQ-010 pb_freq_dn  input  1  raw asynchronous push-button, active-high, lowers the level.
REQ-011 slow_clk  output  1  registered 50% duty square wave at the selected rate.
REQ-012 tick  output  1  one-CLK_50-cycle pulse coincident with each slow_clk 0->1 transition.
REQ-013 freq_num  output  LVL_W  current level, 0 = slowest.
REQ-014 at_min / at_max  output  1 each  freq_num == 0 / freq_num == NUM_LEVELS-1.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser, then a debouncer: debounced level changes only after DB_CYCLES consecutive identical synchronised samples; counter restarts on any mismatch.
REQ-016 A step request SHALL be a 0->1 transition of a debounced button (one request per press, held button gives no further requests).
REQ-017 Up request alone: freq_num +1, saturating at NUM_LEVELS-1; down request alone: freq_num -1, saturating at 0.
REQ-018 Up and down requests in the same cycle: freq_num unchanged.
REQ-019 freq_num SHALL update on the clock edge after the request cycle (latency 1 from debounced edge).
REQ-020 Half-period for level k SHALL be HALF_k = BASE_HALF >> k, constant-evaluated at elaboration; no runtime divider.
REQ-021 Divider counter counts 0..HALF_k-1; on reaching HALF_k-1 it wraps to 0 and slow_clk toggles.
REQ-022 tick SHALL assert in the same cycle slow_clk is registered 0->1, never on 1->0.
REQ-023 On any freq_num change the divider counter SHALL clear to 0 in the same edge freq_num updates; slow_clk keeps its current value (no glitch, no extra toggle).
REQ-024 A toggle coinciding with a level change SHALL be suppressed; the counter clears per REQ-023.
REQ-025 at_min/at_max SHALL be combinational decodes of registered freq_num.
REQ-026 slow_clk SHALL be used only as a data output; no internal logic clocked by it.

Reset
REQ-027 While reset_n low: freq_num=0, slow_clk=0, tick=0, divider counter=0, debouncer counters=0, debounced levels=0, synchroniser flops=0, repeat counters=0.
REQ-028 Reset assertion SHALL take effect asynchronously mid-operation, including mid-debounce and mid-period; deassertion is sampled on CLK_50 and operation restarts from level 0.
REQ-029 A button held through reset deassertion SHALL produce one step after DB_CYCLES (debounced level starts at 0).

Configuration
REQ-030 Macro THROTTLE_AUTOREPEAT_EN defined: while exactly one debounced button stays high, an additional step request SHALL issue every REPEAT_CYCLES clocks after the initial press request; repeat counter clears on release, on both buttons high, and on reset; saturation per REQ-017 still applies.
REQ-031 Macro not defined: repeat logic and REPEAT_CYCLES usage absent; behaviour strictly one step per press.

Verification (NUM_LEVELS=4, BASE_HALF=16, CNT_WIDTH=5, DB_CYCLES=4, REPEAT_CYCLES=20)
REQ-032 Reset then free-run -> slow_clk period 32 clocks, tick every 32 clocks, freq_num=0, at_min=1.
REQ-033 Up press held 10 clocks with 1-clock bounce at start -> exactly one step, freq_num=1, period becomes 16 clocks, slow_clk no glitch at the change.
REQ-034 Five up presses -> freq_num=3, at_max=1, period 4 clocks; further down press with up -> freq_num stays 3 when both debounce in the same cycle.
REQ-035 Three down presses from 0 -> freq_num stays 0, at_min=1.
REQ-036 reset_n pulsed low mid-period at level 2 -> all outputs 0 asynchronously, level 0 after release.
REQ-037 THROTTLE_AUTOREPEAT_EN defined, up held 70 clocks after debounce -> freq_num 0->1->2->3 then holds at 3; macro undefined -> freq_num=1.
